// File: rtl/ram_sp_clr.sv
// Single-port RAM with a registered read port and a one-word-per-cycle clear sweep.
// The sweep runs after reset and on each clr request; accesses are ignored while it runs.
module ram_sp_clr #(
   parameter int DEPTH    = 32,
   parameter int WIDTH    = 8,
   parameter int RDW_MODE = 0,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  din,
   input  logic              wren,
   input  logic              clr,
   output logic [WIDTH-1:0]  dout,
   output logic              valid,
   output logic              busy
);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  dout_q, dout_d;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic              in_range;
   logic [WIDTH-1:0]  rd_word;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [WIDTH-1:0]  mem_wdata;

   // Addresses past the last word are legal on the port but never touch the array.
   assign in_range = ({1'b0, addr} < DEPTH_W);
   assign rd_word  = in_range ? mem[addr] : '0;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      busy_d    = busy_q;
      valid_d   = 1'b0;
      dout_d    = dout_q;
      mem_we    = 1'b0;
      mem_waddr = ptr_q;
      mem_wdata = '0;
      case (state_q)
         CLEAR: begin
            mem_we = 1'b1;
            dout_d = '0;
            if (ptr_q == LAST_PTR) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               ptr_d   = '0;
               busy_d  = 1'b1;
               dout_d  = '0;
            end else begin
               valid_d = 1'b1;
               if (wren) begin
                  mem_we    = in_range;
                  mem_waddr = addr;
                  mem_wdata = din;
                  // Read-first returns the word as it was before this write lands.
                  if (!in_range)         dout_d = '0;
                  else if (RDW_MODE == 0) dout_d = din;
                  else                    dout_d = rd_word;
               end else begin
                  dout_d = rd_word;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         busy_q  <= 1'b1;
         valid_q <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         dout_q  <= dout_d;
      end
   end

   // Array has no reset so it maps onto block RAM; the sweep provides the zeroing.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign dout  = dout_q;
   assign valid = valid_q;
   assign busy  = busy_q;

endmodule

// File: doc/ram_sp_clr.md
RAM_SP_CLR -- requirements
Module: ram_sp_clr

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning number of words (2..1024, need not be a power of 2).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning bits per word (1..64).
REQ-003 The block SHALL have parameter RDW_MODE, default 0, meaning read-during-write behaviour: 0 = write-first (dout gets new data), 1 = read-first (dout gets old data).
REQ-004 The block SHALL have derived parameter ADDR_W, default $clog2(DEPTH), meaning address width.

Interface
REQ-005 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n  input  1  meaning the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port addr  input  ADDR_W  meaning the read/write word address.
REQ-008 The block SHALL have port din  input  WIDTH  meaning write data.
REQ-009 The block SHALL have port wren  input  1  meaning write enable; when 0 the access is a read.
REQ-010 The block SHALL have port clr  input  1  meaning a one-cycle request to zero the whole array.
REQ-011 The block SHALL have port dout  output  WIDTH  meaning registered read data.
REQ-012 The block SHALL have port valid  output  1  meaning dout holds the result of the access sampled at the previous edge.
REQ-013 The block SHALL have port busy  output  1  meaning a clear sweep is in progress and accesses are ignored.

Function
REQ-014 The block SHALL implement a two-state FSM, IDLE and CLEAR, with a clear pointer ptr of ADDR_W bits.
REQ-015 In IDLE with clr=0 and wren=1, each edge SHALL write RAM[addr]<=din and set dout to din (RDW_MODE=0) or the pre-write RAM[addr] (RDW_MODE=1).
REQ-016 In IDLE with clr=0 and wren=0, each edge SHALL set dout<=RAM[addr], giving 1-cycle read latency.
REQ-017 valid SHALL be registered as (state==IDLE && clr==0) at each edge; it is 1 the cycle after every accepted access.
REQ-018 If addr>=DEPTH in IDLE, a write SHALL be dropped with the array unchanged, a read SHALL return dout=0, and valid SHALL still be 1.
REQ-019 clr=1 in IDLE SHALL take priority over wren at the same edge (the write is dropped), and SHALL set state=CLEAR, ptr=0, busy=1, dout=0, valid=0.
REQ-020 In CLEAR, each edge SHALL write RAM[ptr]<=0 and increment ptr.
REQ-021 On the edge writing ptr=DEPTH-1, the FSM SHALL return to IDLE and busy SHALL fall, so busy is high for exactly DEPTH cycles.
REQ-022 While busy, the block SHALL ignore wren, addr, din and clr: there is no restart, dout holds 0 and valid stays 0.
REQ-023 ptr SHALL never exceed DEPTH-1, with no wrap-around writes.
REQ-024 The first access presented while busy=0 SHALL be accepted at that edge.

Reset
REQ-025 reset_n=0 SHALL immediately force state=CLEAR, ptr=0, busy=1, valid=0 and dout=0, regardless of clk.
REQ-026 The array SHALL have no reset; contents SHALL be zeroed by the CLEAR sweep starting at the first rising edge after reset_n rises.
REQ-027 busy SHALL fall after the DEPTH-th edge following reset release.
REQ-028 Assertion of reset_n mid-sweep or mid-access SHALL abort the operation and restart the sweep from ptr=0 after release.

Verification (DEPTH=32, WIDTH=8 unless stated)
REQ-029 The bench SHALL release reset, then read all 32 addresses after busy falls, and SHALL require busy high exactly 32 cycles and every read dout=8'h00 with valid=1.
REQ-030 The bench SHALL write 8'hA5@0, 8'h3C@2 and 8'hFF@31, then read 2, 0 and 31, and SHALL require dout 8'h3C, 8'hA5 and 8'hFF one cycle after each read is presented.
REQ-031 With RDW_MODE=0 and then RDW_MODE=1, the bench SHALL write 8'h11@5 and then write 8'h22@5, and SHALL require dout=8'h22 (mode 0) or dout=8'h11 (mode 1) after the second write.
REQ-032 The bench SHALL assert clr together with wren=1, addr=4, din=8'h77, and SHALL require busy=1 for 32 cycles, writes during busy having no effect, and a later read of 4 returning 8'h00.
REQ-033 With DEPTH=20, the bench SHALL write 8'h9A@25 and then read 25 and 19, and SHALL require dout=8'h00 for both, valid=1, and the sweep length to be 20 cycles.
REQ-034 The bench SHALL assert reset_n=0 asynchronously at sweep ptr=10, and SHALL require busy, valid and dout to go to 1, 0 and 0 before the next edge, and a full 32-cycle sweep after release.
